// File: rtl/qed_pkg.sv
// Shared state type, opcode constants and instruction helpers for the SQED duplicator.
// QED_MEM_DUP_EN: also record and duplicate loads/stores whose base register is x0.
package qed_pkg;

   typedef enum logic [1:0] {ORIG, DUP, DONE} qed_state_e;

   localparam logic [6:0] OPC_R     = 7'b0110011;
   localparam logic [6:0] OPC_I     = 7'b0010011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_NOP   = 7'b1111111;

   localparam logic [31:0] QED_NOP     = 32'h0000007F;
   localparam int unsigned REG_DUP_BIT = 4;

   localparam int unsigned RD_LSB  = 7;
   localparam int unsigned RS1_LSB = 15;
   localparam int unsigned RS2_LSB = 20;

   // Registers are constrained below 16, so OR-ing bit 4 of a field is a +16 remap.
   localparam logic [31:0] RD_DUP  = 32'd1 << (RD_LSB + REG_DUP_BIT);
   localparam logic [31:0] RS1_DUP = 32'd1 << (RS1_LSB + REG_DUP_BIT);
   localparam logic [31:0] RS2_DUP = 32'd1 << (RS2_LSB + REG_DUP_BIT);

`ifdef QED_MEM_DUP_EN
   localparam logic [31:0] LD_IMM_DUP = 32'd1 << 26;
   localparam logic [31:0] ST_IMM_DUP = 32'd1 << 25;
`endif

   function automatic logic is_recorded(input logic [31:0] instr);
      logic rec;
      rec = 1'b0;
      case (instr[6:0])
         OPC_R, OPC_I:        rec = 1'b1;
`ifdef QED_MEM_DUP_EN
         OPC_LOAD, OPC_STORE: rec = (instr[19:15] == 5'd0);
`else
         OPC_LOAD, OPC_STORE: rec = 1'b0;
`endif
         default:             rec = 1'b0;
      endcase
      return rec;
   endfunction

   // Originals that are neither recorded nor NOP reach the decoder as the canonical NOP.
   function automatic logic [31:0] forward(input logic [31:0] instr);
      return (is_recorded(instr) || (instr[6:0] == OPC_NOP)) ? instr : QED_NOP;
   endfunction

   function automatic logic [31:0] dup_xform(input logic [31:0] instr);
      logic [31:0] x;
      x = instr;
      case (instr[6:0])
         OPC_R:     x = instr | RD_DUP | RS1_DUP | RS2_DUP;
         OPC_I:     x = instr | RD_DUP | RS1_DUP;
`ifdef QED_MEM_DUP_EN
         OPC_LOAD:  x = instr | RD_DUP | LD_IMM_DUP;
         OPC_STORE: x = instr | RS2_DUP | ST_IMM_DUP;
`else
         OPC_LOAD, OPC_STORE: x = instr;
`endif
         default:   x = instr;
      endcase
      return x;
   endfunction

endpackage

// File: rtl/qed_duplicator_if.sv
// Fetch, decode and commit signals between the environment and the SQED duplicator.
interface qed_duplicator_if;
   logic [31:0] ifu_instr;
   logic        ifu_valid;
   logic        ifu_ready;
   logic        exec_dup;
   logic [31:0] qed_instr;
   logic        qed_valid;
   logic        qed_is_dup;
   logic        dec_ready;
   logic        commit_valid;
   logic        commit_is_dup;
   logic        qed_ready;

   modport master (
      output ifu_instr, ifu_valid, exec_dup, dec_ready, commit_valid, commit_is_dup,
      input  ifu_ready, qed_instr, qed_valid, qed_is_dup, qed_ready
   );

   modport slave (
      input  ifu_instr, ifu_valid, exec_dup, dec_ready, commit_valid, commit_is_dup,
      output ifu_ready, qed_instr, qed_valid, qed_is_dup, qed_ready
   );
endinterface

// File: rtl/qed_fifo.sv
// Synchronous DEPTH x WIDTH FIFO holding recorded originals; pushes when full and pops when empty are ignored.
module qed_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/qed_duplicator.sv
// SQED duplicator: forwards and records originals, replays them with remapped registers, flags the check point.
// QED_MEM_DUP_EN (see qed_pkg) extends recording and duplication to x0-based loads/stores.
module qed_duplicator
   import qed_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input logic             clk,
   input logic             rst_n,
   qed_duplicator_if.slave io
);

   localparam int unsigned    CW      = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0]  CNT_MAX = CW'(DEPTH);

   qed_state_e    state_q, state_d;

   logic          fifo_push;
   logic          fifo_pop;
   logic [31:0]   fifo_rdata;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;

   logic [31:0]   qed_instr_q;
   logic          qed_valid_q;
   logic          qed_is_dup_q;
   logic          qed_ready_q;

   logic          out_free;
   logic          ready_c;
   logic          out_en;
   logic [31:0]   out_instr;
   logic          out_valid;
   logic          out_dup;

   logic [CW-1:0] n_enq;
   logic [CW-1:0] n_orig_c;
   logic [CW-1:0] n_dup_c;

   qed_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (io.ifu_instr),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign out_free = !qed_valid_q || io.dec_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ORIG;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      ready_c   = 1'b0;
      fifo_push = 1'b0;
      fifo_pop  = 1'b0;
      out_en    = 1'b0;
      out_instr = qed_instr_q;
      out_valid = 1'b0;
      out_dup   = 1'b0;
      case (state_q)
         ORIG: begin
            ready_c = !fifo_full && !io.exec_dup && out_free;
            if (out_free) begin
               out_en = 1'b1;
               if (io.ifu_valid && ready_c) begin
                  out_instr = forward(io.ifu_instr);
                  out_valid = 1'b1;
                  fifo_push = is_recorded(io.ifu_instr);
               end
            end
            // The DEPTH-th push and the switch to replay share one edge.
            if (io.exec_dup)
               state_d = fifo_empty ? DONE : DUP;
            else if (fifo_push && (fifo_count == CNT_MAX - 1'b1))
               state_d = DUP;
         end
         DUP: begin
            if (out_free) begin
               out_en = 1'b1;
               if (!fifo_empty) begin
                  fifo_pop  = 1'b1;
                  out_instr = dup_xform(fifo_rdata);
                  out_valid = 1'b1;
                  out_dup   = 1'b1;
               end
            end
            if (fifo_empty || (fifo_pop && (fifo_count == CW'(1))))
               state_d = DONE;
         end
         DONE: begin
            if (out_free) begin
               out_en    = 1'b1;
               out_instr = QED_NOP;
               out_valid = 1'b1;
            end
         end
         default: state_d = ORIG;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qed_instr_q  <= '0;
         qed_valid_q  <= 1'b0;
         qed_is_dup_q <= 1'b0;
      end else if (out_en) begin
         qed_instr_q  <= out_instr;
         qed_valid_q  <= out_valid;
         qed_is_dup_q <= out_dup;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_enq    <= '0;
         n_orig_c <= '0;
         n_dup_c  <= '0;
      end else begin
         if (fifo_push && (n_enq < CNT_MAX))
            n_enq <= n_enq + 1'b1;
         if (io.commit_valid && !io.commit_is_dup && (n_orig_c < CNT_MAX))
            n_orig_c <= n_orig_c + 1'b1;
         if (io.commit_valid && io.commit_is_dup && (n_dup_c < CNT_MAX))
            n_dup_c <= n_dup_c + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) qed_ready_q <= 1'b0;
      else        qed_ready_q <= (state_q == DONE) && (n_enq != '0) &&
                                 (n_orig_c == n_enq) && (n_dup_c == n_enq);
   end

   assign io.ifu_ready  = ready_c;
   assign io.qed_instr  = qed_instr_q;
   assign io.qed_valid  = qed_valid_q;
   assign io.qed_is_dup = qed_is_dup_q;
   assign io.qed_ready  = qed_ready_q;

endmodule

// File: tb/tb_qed_duplicator.sv
// Directed bench for qed_duplicator: forwarding, replay, full boundary, stall, check point and reset.
module tb_qed_duplicator;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   qed_duplicator_if io ();

   qed_duplicator #(
      .DEPTH (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (io)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   function automatic logic [31:0] add_k(input int unsigned k);
      return 32'h00310033 | ((k + 1) << 7);
   endfunction

   initial begin
      n_checks         = 0;
      n_fail           = 0;
      rst_n            = 1'b0;
      io.ifu_instr     = '0;
      io.ifu_valid     = 1'b0;
      io.exec_dup      = 1'b0;
      io.dec_ready     = 1'b1;
      io.commit_valid  = 1'b0;
      io.commit_is_dup = 1'b0;

      // Reset and idle
      do_reset();
      step();
      chk("rst_ifu_ready", io.ifu_ready, 1);
      chk("rst_qed_valid", io.qed_valid, 0);
      chk("rst_qed_instr", io.qed_instr, 0);
      chk("rst_qed_is_dup", io.qed_is_dup, 0);
      chk("rst_qed_ready", io.qed_ready, 0);

      // ADD, then exec_dup
      io.ifu_instr = 32'h003100B3;
      io.ifu_valid = 1'b1;
      step();
      chk("add_orig", io.qed_instr, 32'h003100B3);
      chk("add_orig_dup", io.qed_is_dup, 0);
      chk("add_orig_valid", io.qed_valid, 1);
      io.ifu_valid = 1'b0;
      io.exec_dup  = 1'b1;
      #1;
      chk("exec_dup_blocks", io.ifu_ready, 0);
      step();
      io.exec_dup = 1'b0;
      step();
      chk("add_dup", io.qed_instr, 32'h013908B3);
      chk("add_dup_flag", io.qed_is_dup, 1);
      chk("add_dup_valid", io.qed_valid, 1);
      step();
      chk("add_done_nop", io.qed_instr, 32'h0000007F);
      chk("add_done_flag", io.qed_is_dup, 0);
      chk("add_done_valid", io.qed_valid, 1);
      chk("add_done_ready", io.ifu_ready, 0);

      // ADDI, NOP, LUI; only the ADDI is replayed
      do_reset();
      io.ifu_instr = 32'h00730293;
      io.ifu_valid = 1'b1;
      step();
      chk("addi_orig", io.qed_instr, 32'h00730293);
      io.ifu_instr = 32'h0000007F;
      step();
      chk("nop_fwd", io.qed_instr, 32'h0000007F);
      io.ifu_instr = 32'h123450B7;
      step();
      chk("lui_to_nop", io.qed_instr, 32'h0000007F);
      chk("lui_valid", io.qed_valid, 1);
      io.ifu_valid = 1'b0;
      io.exec_dup  = 1'b1;
      step();
      io.exec_dup = 1'b0;
      step();
      chk("addi_dup", io.qed_instr, 32'h007B0A93);
      chk("addi_dup_flag", io.qed_is_dup, 1);
      step();
      chk("addi_after_nop", io.qed_instr, 32'h0000007F);
      chk("addi_after_flag", io.qed_is_dup, 0);

      // Eight ADDs fill the FIFO; replay includes a three-cycle decoder stall
      do_reset();
      for (int unsigned k = 0; k < 8; k++) begin
         io.ifu_instr = add_k(k);
         io.ifu_valid = 1'b1;
         #1;
         chk($sformatf("fill_ready_%0d", k), io.ifu_ready, 1);
         step();
         chk($sformatf("fill_out_%0d", k), io.qed_instr, add_k(k));
      end
      io.ifu_valid = 1'b0;
      chk("full_ready_low", io.ifu_ready, 0);
      chk("full_last_orig_flag", io.qed_is_dup, 0);
      for (int unsigned k = 0; k < 8; k++) begin
         step();
         chk($sformatf("fill_dup_%0d", k), io.qed_instr, add_k(k) | 32'h01080800);
         chk($sformatf("fill_dup_flag_%0d", k), io.qed_is_dup, 1);
         if (k == 2) begin
            io.dec_ready = 1'b0;
            for (int unsigned s = 0; s < 3; s++) begin
               step();
               chk($sformatf("stall_hold_%0d", s), io.qed_instr, add_k(2) | 32'h01080800);
               chk($sformatf("stall_valid_%0d", s), io.qed_valid, 1);
            end
            io.dec_ready = 1'b1;
         end
      end
      step();
      chk("fill_done_nop", io.qed_instr, 32'h0000007F);
      chk("fill_done_flag", io.qed_is_dup, 0);
      step();
      chk("fill_done_nop2", io.qed_instr, 32'h0000007F);

      // Two originals, two duplicates, four commits -> check point
      do_reset();
      io.ifu_instr = 32'h00100093;
      io.ifu_valid = 1'b1;
      step();
      io.ifu_instr = 32'h00208113;
      step();
      io.ifu_valid = 1'b0;
      io.exec_dup  = 1'b1;
      step();
      io.exec_dup      = 1'b0;
      io.commit_valid  = 1'b1;
      io.commit_is_dup = 1'b0;
      step();
      chk("cp_dup1", io.qed_instr, 32'h00180893);
      step();
      chk("cp_dup2", io.qed_instr, 32'h00288913);
      chk("cp_ready_pre", io.qed_ready, 0);
      io.commit_is_dup = 1'b1;
      step();
      chk("cp_ready_one_dup", io.qed_ready, 0);
      step();
      chk("cp_ready_at_commit", io.qed_ready, 0);
      io.commit_valid  = 1'b0;
      io.commit_is_dup = 1'b0;
      step();
      chk("cp_ready_set", io.qed_ready, 1);
      step();
      chk("cp_ready_holds", io.qed_ready, 1);

      // Reset asserted mid-replay
      do_reset();
      io.ifu_instr = add_k(0);
      io.ifu_valid = 1'b1;
      step();
      io.ifu_instr = add_k(1);
      step();
      io.ifu_valid = 1'b0;
      io.exec_dup  = 1'b1;
      step();
      io.exec_dup = 1'b0;
      step();
      chk("mid_dup_flag", io.qed_is_dup, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", io.qed_valid, 0);
      chk("mid_rst_instr", io.qed_instr, 0);
      chk("mid_rst_flag", io.qed_is_dup, 0);
      chk("mid_rst_ready", io.qed_ready, 0);
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst_ifu_ready", io.ifu_ready, 1);
      io.exec_dup = 1'b1;
      step();
      io.exec_dup = 1'b0;
      step();
      chk("post_rst_empty_nop", io.qed_instr, 32'h0000007F);
      chk("post_rst_empty_flag", io.qed_is_dup, 0);
      chk("post_rst_empty_ready", io.qed_ready, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
